// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU result as an effective address, steers byte lanes for stores,
// extracts and extends load data, and runs one REQ/ACK transaction at a time to data memory.
// Every output comes straight from a flop.
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [6:0]      OPCODE,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] ALU_OUT,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic [4:0]      RD,
  output logic            BUSY,
  output logic            MEM_REQ,
  output logic            MEM_WE,
  output logic [XLEN-1:0] MEM_ADDR,
  output logic [3:0]      MEM_BE,
  output logic [XLEN-1:0] MEM_WDATA,
  input  logic [XLEN-1:0] MEM_RDATA,
  input  logic            MEM_ACK,
  output logic            WB_VALID,
  output logic [XLEN-1:0] WB_DATA,
  output logic [4:0]      WB_RD,
  output logic            MISALIGN
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [0:0] {StIdle, StReq} state_e;
  typedef enum logic [1:0] {SzByte = 2'b00, SzHalf = 2'b01, SzWord = 2'b10} size_e;

  state_e          state_q, state_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            misalign_q, misalign_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      lane_q, lane_d;
  logic [4:0]      rd_q, rd_d;

  // Decoded view of the instruction currently presented by execute.
  logic            dec_load, dec_store, dec_legal, dec_misalign;
  size_e           dec_size;
  logic [3:0]      dec_be;
  logic [XLEN-1:0] dec_wdata;

  // Load data after lane extraction and sign/zero extension.
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_ext;

  // Decode opcode/funct3 into legality, size, alignment, byte enables and store data.
  always_comb begin
    dec_load     = (OPCODE == OpLoad);
    dec_store    = (OPCODE == OpStore);
    dec_legal    = 1'b0;
    dec_size     = SzWord;
    dec_misalign = 1'b0;
    dec_be       = 4'b1111;
    dec_wdata    = RS2_DATA;

    if (dec_load) begin
      unique case (FUNCT3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_legal = 1'b1;
        default:                                dec_legal = 1'b0;
      endcase
    end else if (dec_store) begin
      unique case (FUNCT3)
        3'b000, 3'b001, 3'b010: dec_legal = 1'b1;
        default:                dec_legal = 1'b0;
      endcase
    end

    unique case (FUNCT3[1:0])
      2'b00: begin
        dec_size  = SzByte;
        dec_be    = 4'b0001 << ALU_OUT[1:0];
        dec_wdata = {4{RS2_DATA[7:0]}};
      end
      2'b01: begin
        dec_size     = SzHalf;
        dec_misalign = ALU_OUT[0];
        dec_be       = ALU_OUT[1] ? 4'b1100 : 4'b0011;
        dec_wdata    = {2{RS2_DATA[15:0]}};
      end
      default: begin
        dec_size     = SzWord;
        dec_misalign = (ALU_OUT[1:0] != 2'b00);
        dec_be       = 4'b1111;
        dec_wdata    = RS2_DATA;
      end
    endcase
  end

  // Pick the addressed lane(s) out of the returned word and extend to XLEN.
  always_comb begin
    rdata_shifted = MEM_RDATA >> {lane_q, 3'b000};
    load_ext      = MEM_RDATA;
    unique case (size_q)
      SzByte: load_ext = uns_q ? {{(XLEN-8){1'b0}}, rdata_shifted[7:0]}
                               : {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      SzHalf: load_ext = uns_q ? {{(XLEN-16){1'b0}}, rdata_shifted[15:0]}
                               : {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = MEM_RDATA;
    endcase
  end

  // Next-state logic: accept in idle, wait for ACK in request, pulse writeback/misalign.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    misalign_d  = 1'b0;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    rd_d        = rd_q;

    unique case (state_q)
      StIdle: begin
        if (START && dec_legal) begin
          if (dec_misalign) begin
            // Dropped: no request is issued and the pipeline is not stalled.
            misalign_d = 1'b1;
          end else begin
            state_d     = StReq;
            mem_we_d    = dec_store;
            mem_addr_d  = {ALU_OUT[XLEN-1:2], 2'b00};
            mem_be_d    = dec_be;
            mem_wdata_d = dec_wdata;
            size_d      = dec_size;
            uns_d       = FUNCT3[2];
            lane_d      = ALU_OUT[1:0];
            rd_d        = RD;
          end
        end
      end
      StReq: begin
        if (MEM_ACK) begin
          state_d = StIdle;
          if (!mem_we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = load_ext;
            wb_rd_d    = rd_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= 5'd0;
      misalign_q  <= 1'b0;
      size_q      <= SzByte;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      rd_q        <= 5'd0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      misalign_q  <= misalign_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
    end
  end

  assign BUSY      = (state_q == StReq);
  assign MEM_REQ   = (state_q == StReq);
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_WDATA = mem_wdata_q;
  assign WB_VALID  = wb_valid_q;
  assign WB_DATA   = wb_data_q;
  assign WB_RD     = wb_rd_q;
  assign MISALIGN  = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected memory requests and writebacks are queued when
// stimulus is driven; a memory responder and a writeback monitor pop and compare them.
module tb_load_store_unit;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [6:0]  OPCODE = 7'd0;
  logic [2:0]  FUNCT3 = 3'd0;
  logic [31:0] ALU_OUT = 32'd0;
  logic [31:0] RS2_DATA = 32'd0;
  logic [4:0]  RD = 5'd0;
  logic        BUSY, MEM_REQ, MEM_WE, WB_VALID, MISALIGN;
  logic [31:0] MEM_ADDR, MEM_WDATA, WB_DATA;
  logic [3:0]  MEM_BE;
  logic [4:0]  WB_RD;
  logic [31:0] MEM_RDATA = 32'd0;
  logic        MEM_ACK = 1'b0;

  load_store_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
    .ALU_OUT(ALU_OUT), .RS2_DATA(RS2_DATA), .RD(RD), .BUSY(BUSY), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .WB_VALID(WB_VALID), .WB_DATA(WB_DATA),
    .WB_RD(WB_RD), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   wb_pushed = 0;
  int   wb_seen = 0;
  int   mis_seen = 0;
  logic stray_ack = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    req_t r;
    r.we = we; r.addr = addr; r.be = be; r.wdata = wdata; r.rdata = rdata; r.delay = delay;
    req_q.push_back(r);
  endtask

  task automatic push_wb(input logic [31:0] data, input logic [4:0] rd);
    wb_t w;
    w.data = data; w.rd = rd;
    wb_q.push_back(w);
    wb_pushed++;
  endtask

  // Present an instruction, hold it until BUSY is low, return #1 after the accepting edge.
  task automatic lsu_issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [4:0] rd);
    int n = 0;
    @(negedge CLK);
    START = 1'b1; OPCODE = op; FUNCT3 = f3; ALU_OUT = addr; RS2_DATA = rs2; RD = rd;
    while (BUSY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check_eq("issue_timeout", 32'(n), 32'd0);
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((BUSY || req_q.size() != 0 || wb_q.size() != 0) && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", 32'(n), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic load_case(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] be,
                           input logic [31:0] exp, input logic [4:0] rd);
    push_req(1'b0, {addr[31:2], 2'b00}, be, 32'd0, rdata, 0);
    push_wb(exp, rd);
    lsu_issue(OpLoad, f3, addr, 32'd0, rd);
    drain();
  endtask

  task automatic store_case(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [3:0] be,
                            input logic [31:0] wdata, input int delay);
    push_req(1'b1, {addr[31:2], 2'b00}, be, wdata, 32'd0, delay);
    lsu_issue(OpStore, f3, addr, rs2, 5'd0);
  endtask

  // Memory responder: pops the expected request when REQ rises, checks it every REQ cycle,
  // and drives ACK after the queued delay.
  initial begin : responder
    req_t cur;
    int   cnt;
    logic in_req;
    in_req = 1'b0;
    cnt = 0;
    cur = '{we: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, rdata: 32'd0, delay: 0};
    forever begin
      @(negedge CLK);
      if (MEM_REQ) begin
        if (!in_req) begin
          in_req = 1'b1;
          if (req_q.size() == 0) begin
            check_eq("req_unexpected", 32'd1, 32'd0);
            cnt = 0;
          end else begin
            cur = req_q.pop_front();
            cnt = cur.delay;
          end
        end
        check_eq("req_we", 32'(MEM_WE), 32'(cur.we));
        check_eq("req_addr", MEM_ADDR, cur.addr);
        check_eq("req_be", 32'(MEM_BE), 32'(cur.be));
        if (cur.we) check_eq("req_wdata", MEM_WDATA, cur.wdata);
        check_eq("req_busy", 32'(BUSY), 32'd1);
        if (cnt == 0) begin
          MEM_ACK = 1'b1;
          MEM_RDATA = cur.rdata;
        end else begin
          MEM_ACK = 1'b0;
          cnt--;
        end
      end else begin
        in_req = 1'b0;
        MEM_ACK = stray_ack;
        MEM_RDATA = 32'hBAD0_BAD0;
      end
    end
  end

  // Writeback monitor and misalign pulse counter.
  initial begin : wb_monitor
    wb_t w;
    forever begin
      @(negedge CLK);
      if (WB_VALID) begin
        wb_seen++;
        if (wb_q.size() == 0) begin
          check_eq("wb_unexpected", 32'd1, 32'd0);
        end else begin
          w = wb_q.pop_front();
          check_eq("wb_data", WB_DATA, w.data);
          check_eq("wb_rd", 32'(WB_RD), 32'(w.rd));
        end
      end
      if (MISALIGN) mis_seen++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    // Reset: all outputs low one edge after RST is sampled.
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_req", 32'(MEM_REQ), 32'd0);
    check_eq("rst_wb_valid", 32'(WB_VALID), 32'd0);
    check_eq("rst_wb_data", WB_DATA, 32'd0);
    check_eq("rst_misalign", 32'(MISALIGN), 32'd0);
    check_eq("rst_be", 32'(MEM_BE), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // LW with zero-wait ACK: request in cycle 1, writeback in cycle 2.
    push_req(1'b0, 32'h100, 4'b1111, 32'd0, 32'hDEADBEEF, 0);
    push_wb(32'hDEADBEEF, 5'd5);
    lsu_issue(OpLoad, 3'b010, 32'h100, 32'd0, 5'd5);
    check_eq("lw_c1_req", 32'(MEM_REQ), 32'd1);
    check_eq("lw_c1_wbv", 32'(WB_VALID), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("lw_c2_wbv", 32'(WB_VALID), 32'd1);
    check_eq("lw_c2_data", WB_DATA, 32'hDEADBEEF);
    check_eq("lw_c2_rd", 32'(WB_RD), 32'd5);
    check_eq("lw_c2_busy", 32'(BUSY), 32'd0);
    drain();

    // Sub-word loads: lane selection and extension.
    load_case(3'b000, 32'h103, 32'h80123456, 4'b1000, 32'hFFFFFF80, 5'd6);
    load_case(3'b100, 32'h103, 32'h80123456, 4'b1000, 32'h00000080, 5'd7);
    load_case(3'b001, 32'h102, 32'h80015678, 4'b1100, 32'hFFFF8001, 5'd8);
    load_case(3'b101, 32'h100, 32'h1234F00D, 4'b0011, 32'h0000F00D, 5'd9);
    load_case(3'b000, 32'h101, 32'h00007F00, 4'b0010, 32'h0000007F, 5'd10);
    load_case(3'b101, 32'h102, 32'hF00D1234, 4'b1100, 32'h0000F00D, 5'd11);
    load_case(3'b001, 32'h100, 32'h0000FFFE, 4'b0011, 32'hFFFFFFFE, 5'd12);

    // SH with ACK in cycle 4: BUSY/REQ high cycles 1-4, no writeback.
    store_case(3'b001, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 3);
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("sh_busy_c%0d", i), 32'(BUSY), 32'd1);
      check_eq($sformatf("sh_wbv_c%0d", i), 32'(WB_VALID), 32'd0);
      @(posedge CLK);
      #1;
    end
    check_eq("sh_c5_busy", 32'(BUSY), 32'd0);
    check_eq("sh_c5_wbv", 32'(WB_VALID), 32'd0);
    drain();

    store_case(3'b000, 32'h011, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 0);
    drain();
    store_case(3'b000, 32'h013, 32'hFFFFFF3C, 4'b1000, 32'h3C3C3C3C, 1);
    drain();
    store_case(3'b001, 32'h200, 32'hFFFF0102, 4'b0011, 32'h01020102, 0);
    drain();
    store_case(3'b010, 32'h010, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0);
    drain();
    check_eq("wb_hold_data", WB_DATA, 32'hFFFFFFFE);
    check_eq("wb_hold_rd", 32'(WB_RD), 32'd12);

    // Misaligned accesses: single MISALIGN pulse, no request, BUSY stays low.
    lsu_issue(OpLoad, 3'b010, 32'h101, 32'd0, 5'd3);
    check_eq("mis_lw_pulse", 32'(MISALIGN), 32'd1);
    check_eq("mis_lw_busy", 32'(BUSY), 32'd0);
    check_eq("mis_lw_req", 32'(MEM_REQ), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("mis_lw_c2", 32'(MISALIGN), 32'd0);
    lsu_issue(OpStore, 3'b001, 32'h203, 32'h55, 5'd0);
    check_eq("mis_sh_pulse", 32'(MISALIGN), 32'd1);
    check_eq("mis_sh_busy", 32'(BUSY), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("mis_sh_c2", 32'(MISALIGN), 32'd0);

    // Illegal opcode / funct3 combinations are ignored entirely.
    lsu_issue(7'b0110011, 3'b010, 32'h101, 32'd0, 5'd1);
    check_eq("ill_op_busy", 32'(BUSY), 32'd0);
    check_eq("ill_op_mis", 32'(MISALIGN), 32'd0);
    lsu_issue(OpStore, 3'b100, 32'h100, 32'd0, 5'd1);
    check_eq("ill_st_busy", 32'(BUSY), 32'd0);
    lsu_issue(OpLoad, 3'b011, 32'h101, 32'd0, 5'd1);
    check_eq("ill_ld_busy", 32'(BUSY), 32'd0);
    check_eq("ill_ld_mis", 32'(MISALIGN), 32'd0);
    check_eq("mis_count", 32'(mis_seen), 32'd2);

    // Reset during an unacknowledged LW, then a stray ACK, then a normal SW.
    push_req(1'b0, 32'h300, 4'b1111, 32'd0, 32'h11111111, 1000);
    lsu_issue(OpLoad, 3'b010, 32'h300, 32'd0, 5'd4);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_eq("rr_busy", 32'(BUSY), 32'd0);
    check_eq("rr_req", 32'(MEM_REQ), 32'd0);
    check_eq("rr_we", 32'(MEM_WE), 32'd0);
    check_eq("rr_addr", MEM_ADDR, 32'd0);
    check_eq("rr_be", 32'(MEM_BE), 32'd0);
    check_eq("rr_wdata", MEM_WDATA, 32'd0);
    check_eq("rr_wb_data", WB_DATA, 32'd0);
    check_eq("rr_wb_rd", 32'(WB_RD), 32'd0);
    @(posedge CLK);
    #1;
    stray_ack = 1'b1;
    @(posedge CLK);
    #1;
    stray_ack = 1'b0;
    check_eq("stray_busy", 32'(BUSY), 32'd0);
    check_eq("stray_wbv", 32'(WB_VALID), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("stray_wbv2", 32'(WB_VALID), 32'd0);
    store_case(3'b010, 32'h010, 32'h11223344, 4'b1111, 32'h11223344, 0);
    drain();

    // Back-to-back loads with START held while BUSY: ACK cycle 3, second accepted cycle 4.
    push_req(1'b0, 32'h400, 4'b1111, 32'd0, 32'hAAAA5555, 2);
    push_wb(32'hAAAA5555, 5'd20);
    push_req(1'b0, 32'h404, 4'b1111, 32'd0, 32'h13572468, 0);
    push_wb(32'h13572468, 5'd21);
    lsu_issue(OpLoad, 3'b010, 32'h400, 32'd0, 5'd20);
    lsu_issue(OpLoad, 3'b010, 32'h404, 32'd0, 5'd21);
    check_eq("b2b_c5_req", 32'(MEM_REQ), 32'd1);
    check_eq("b2b_c5_wbv", 32'(WB_VALID), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("b2b_c6_wbv", 32'(WB_VALID), 32'd1);
    check_eq("b2b_c6_data", WB_DATA, 32'h13572468);
    drain();

    check_eq("wb_count", 32'(wb_seen), 32'(wb_pushed));
    check_eq("req_left", 32'(req_q.size()), 32'd0);
    check_eq("mis_final", 32'(mis_seen), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
